add4_serial_ctrl: RTL and testbench
===================================

// Module: add4_serial_ctrl
// PURPOSE
//  Sequencer that reuses one external 4-bit ripple adder (add_4) to add
//  wide operands nibble-serially, LSB nibble first, with a registered carry
//  between passes. It sits between a requester (start/busy/done handshake)
//  and the add_4 instance: it drives add_4 inputs and collects its outputs.
//  Trades latency for area wherever wide adds are infrequent.
// PARAMETERS
//  NIBBLES  4  operand width in nibbles (W = 4*NIBBLES bits); legal range >= 1
// PORTS
//  clk       in   1   clock, rising edge
//  rst_n     in   1   asynchronous reset, active low
//  start     in   1   request; sampled only in IDLE or DONE
//  op_a      in   W   operand A, captured on the accepting edge
//  op_b      in   W   operand B, captured on the accepting edge
//  op_cin    in   1   carry in to nibble 0, captured on the accepting edge
//  busy      out  1   high while the block is in RUN
//  done      out  1   single-cycle pulse: result valid
//  sum       out  W   result; held stable from done until the next accept
//  cout      out  1   carry out of the top nibble; held like sum
//  add_a     out  4   to add_4 .a: nibble idx of captured A
//  add_b     out  4   to add_4 .b: nibble idx of captured B (see CONFIGURATION)
//  add_cin   out  1   to add_4 .cin: carry register
//  add_out   in   4   from add_4 .out
//  add_cout  in   1   from add_4 .cout
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, idx=0, carry=0, busy=0, done=0,
//    sum=0, cout=0; A/B registers cleared. add_* outputs are 0 during reset.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE/DONE --start=1--> RUN. Capture op_a/op_b/op_cin, idx=0, carry=op_cin.
//    RUN: each edge writes add_out into sum[4*idx+:4], carry<=add_cout, idx++.
//    RUN -> DONE on the edge that writes nibble NIBBLES-1; cout<=add_cout.
//    DONE -> IDLE after 1 cycle unless start=1 (back-to-back accept into RUN).
//  - add_a/add_b/add_cin are combinational from the registers (mux by idx).
//    add_4 is purely combinational, so each nibble completes in one cycle.
//  - Latency: with the accept edge counted as E0, done is high during the
//    cycle that follows edge E(NIBBLES). busy is high from E0 to E(NIBBLES).
//    Throughput is one op per NIBBLES+1 cycles.
//  - done is a registered single-cycle pulse. It is never high together
//    with busy.
//  - start while busy=1 is ignored; no queuing and no error flag.
//  - sum is written nibble by nibble during RUN. Its contents are only
//    defined while done=1 and afterwards. The previous result is not preserved
//    once a new op is accepted.
//  - idx width = max(1, clog2(NIBBLES)). NIBBLES=1 gives a single RUN cycle.
//  - Result = (op_a + op_b' + op_cin) mod 2^W; cout = bit W.
//  - rst_n low mid-RUN aborts immediately to reset values. There is no done
//    pulse for the aborted op.
// CONFIGURATION
//  ADD4_SERIAL_SUB_EN defined: adds input port op_sub (1 bit), captured on
//    accept. When op_sub=1, add_b = ~B nibble and carry initialises to 1
//    (op_cin ignored). The result is A-B; cout=1 means no borrow.
//    When op_sub=0, the behaviour is identical to the undefined case.
//  Undefined: op_sub port absent; add_b = B nibble; carry initialises to op_cin.
// TESTING (NIBBLES=4 unless noted)
//  1 0x1234+0x4321, cin=0 -> sum=0x5555, cout=0, done exactly 4 cycles after accept
//  2 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all nibbles)
//  3 0xFFFF+0xFFFF, cin=1 -> sum=0xFFFF, cout=1. Then start held high in the
//    DONE cycle -> 2nd op accepted with no IDLE gap.
//  4 start pulsed at RUN idx=1 with different operands -> ignored; the 1st result
//    is unchanged and there is exactly one done pulse.
//  5 rst_n low at RUN idx=2 -> all outputs 0 asynchronously, no done pulse;
//    the next op completes correctly.
//  6 ADD4_SERIAL_SUB_EN: 0x0005-0x0007 -> sum=0xFFFE, cout=0;
//    0x0007-0x0005 -> sum=0x0002, cout=1. Also NIBBLES=1: 0xF+0x1 -> sum=0x0,
//    cout=1, done 1 cycle after accept.

Source files
------------

// File: rtl/add4_serial_ctrl_if.sv
// Bundles the requester handshake/operand bus and the add_4 connection bus
// used by add4_serial_ctrl. The slave modport is the sequencer itself; the
// master modport is its environment (requester plus the external add_4).
// Optional feature macro: ADD4_SERIAL_SUB_EN adds the op_sub request bit.
interface add4_serial_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
`ifdef ADD4_SERIAL_SUB_EN
    logic         op_sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_out;
    logic         add_cout;

    modport slave (
`ifdef ADD4_SERIAL_SUB_EN
        input  op_sub,
`endif
        input  start, op_a, op_b, op_cin, add_out, add_cout,
        output busy, done, sum, cout, add_a, add_b, add_cin
    );

    modport master (
`ifdef ADD4_SERIAL_SUB_EN
        output op_sub,
`endif
        output start, op_a, op_b, op_cin, add_out, add_cout,
        input  busy, done, sum, cout, add_a, add_b, add_cin
    );
endinterface

// File: rtl/add4_serial_ctrl.sv
// Nibble-serial wide adder sequencer. Reuses one external combinational
// 4-bit adder (add_4), feeding it one nibble of the captured operands per
// cycle, LSB nibble first, with a registered carry between passes.
// Optional feature macro: ADD4_SERIAL_SUB_EN enables subtraction (A-B) via
// inverted B nibbles and a forced carry-in of 1.
module add4_serial_ctrl #(
    parameter int NIBBLES = 4
) (
    input logic                clk,
    input logic                rst_n,
    add4_serial_ctrl_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic [3:0]    nib_b;
`ifdef ADD4_SERIAL_SUB_EN
    logic          sub_q, sub_d;
    logic          init_carry;
`endif

    // Present the current nibble pair and the running carry to add_4.
    always_comb begin
        nib_b        = b_q[4*int'(idx_q) +: 4];
        bus.add_a    = a_q[4*int'(idx_q) +: 4];
`ifdef ADD4_SERIAL_SUB_EN
        bus.add_b    = sub_q ? ~nib_b : nib_b;
`else
        bus.add_b    = nib_b;
`endif
        bus.add_cin  = carry_q;
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

`ifdef ADD4_SERIAL_SUB_EN
    // Subtraction is A + ~B + 1, so the incoming carry is forced high.
    assign init_carry = bus.op_sub ? 1'b1 : bus.op_cin;
`endif

    // Next-state logic: accept in IDLE/DONE, step one nibble per RUN cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef ADD4_SERIAL_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
`ifdef ADD4_SERIAL_SUB_EN
                    sub_d   = bus.op_sub;
                    carry_d = init_carry;
`else
                    carry_d = bus.op_cin;
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[4*int'(idx_q) +: 4] = bus.add_out;
                carry_d = bus.add_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    cout_d  = bus.add_cout;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything so the add_4
    // inputs also read zero while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ADD4_SERIAL_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef ADD4_SERIAL_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end
endmodule

// File: tb/tb_add4_serial_ctrl.sv
// Testbench for add4_serial_ctrl: a 4-nibble instance driven from a vector
// table plus hand-written multi-cycle sequences, and a 1-nibble instance.
// The external add_4 is modelled here as a combinational 5-bit add.
module tb_add4_serial_ctrl;
    logic clk;
    logic rst_n;

    add4_serial_ctrl_if #(.NIBBLES(4)) bus  ();
    add4_serial_ctrl_if #(.NIBBLES(1)) bus1 ();

    add4_serial_ctrl #(.NIBBLES(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    add4_serial_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Behavioural add_4 instances.
    assign {bus.add_cout, bus.add_out} =
        {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};
    assign {bus1.add_cout, bus1.add_out} =
        {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {4'b0, bus1.add_cin};

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] expSum;
        logic        expCout;
    } vec_t;

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: request an op, return at the negedge after the
    // accepting edge with start released.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin);
        bus.start  = 1'b1;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.op_cin = cin;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Step negedges until done, bounded; reports cycles and busy/done overlap.
    task automatic waitDone(output int cycles, output logic overlap);
        cycles  = 0;
        overlap = 1'b0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (bus.busy === 1'b1 && bus.done === 1'b1) overlap = 1'b1;
        end
        if (bus.done !== 1'b1) checkOutput("doneTimeout", 32'd0, 32'd1);
    endtask

    vec_t vecs[8];
    vec_t vecs1[3];
    int   cycles;
    logic overlap;
    int   donePulses;

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[6] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

        vecs1[0] = '{16'h000F, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs1[1] = '{16'h0003, 16'h0004, 1'b1, 16'h0008, 1'b0};
        vecs1[2] = '{16'h0007, 16'h0008, 1'b1, 16'h0000, 1'b1};

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op_a    = '0;
        bus.op_b    = '0;
        bus.op_cin  = 1'b0;
        bus1.start  = 1'b0;
        bus1.op_a   = '0;
        bus1.op_b   = '0;
        bus1.op_cin = 1'b0;
`ifdef ADD4_SERIAL_SUB_EN
        bus.op_sub  = 1'b0;
        bus1.op_sub = 1'b0;
`endif

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rstBusy", {31'b0, bus.busy}, 32'd0);
        checkOutput("rstDone", {31'b0, bus.done}, 32'd0);
        checkOutput("rstSum", {16'b0, bus.sum}, 32'd0);
        checkOutput("rstCout", {31'b0, bus.cout}, 32'd0);
        checkOutput("rstAdd", {23'b0, bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors, including latency and single-pulse done.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
            checkOutput($sformatf("v%0d.busyRun", i), {31'b0, bus.busy}, 32'd1);
            waitDone(cycles, overlap);
            checkOutput($sformatf("v%0d.latency", i), cycles, 32'd4);
            checkOutput($sformatf("v%0d.overlap", i), {31'b0, overlap}, 32'd0);
            checkOutput($sformatf("v%0d.sum", i), {16'b0, bus.sum}, {16'b0, vecs[i].expSum});
            checkOutput($sformatf("v%0d.cout", i), {31'b0, bus.cout}, {31'b0, vecs[i].expCout});
            @(negedge clk);
            checkOutput($sformatf("v%0d.donePulse", i), {31'b0, bus.done}, 32'd0);
            checkOutput($sformatf("v%0d.sumHeld", i), {16'b0, bus.sum}, {16'b0, vecs[i].expSum});
        end

        // Back-to-back: start held in the DONE cycle gives no IDLE gap.
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
        waitDone(cycles, overlap);
        checkOutput("b2b.sum1", {16'b0, bus.sum}, 32'h0000FFFF);
        checkOutput("b2b.cout1", {31'b0, bus.cout}, 32'd1);
        applyStimulus(16'h1111, 16'h2222, 1'b0);
        checkOutput("b2b.busyNoGap", {31'b0, bus.busy}, 32'd1);
        checkOutput("b2b.doneLow", {31'b0, bus.done}, 32'd0);
        waitDone(cycles, overlap);
        checkOutput("b2b.latency", cycles, 32'd4);
        checkOutput("b2b.sum2", {16'b0, bus.sum}, 32'h00003333);
        checkOutput("b2b.cout2", {31'b0, bus.cout}, 32'd0);
        @(negedge clk);

        // Start pulsed while busy (idx=1) is ignored.
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 16'hAAAA;
        bus.op_b  = 16'h5555;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(cycles, overlap);
        checkOutput("ign.latency", cycles, 32'd2);
        checkOutput("ign.sum", {16'b0, bus.sum}, 32'h00005555);
        checkOutput("ign.cout", {31'b0, bus.cout}, 32'd0);
        donePulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) donePulses++;
        end
        checkOutput("ign.noSecondOp", donePulses, 32'd0);

        // Reset asserted mid-RUN at idx=2 aborts immediately.
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort.busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("abort.done", {31'b0, bus.done}, 32'd0);
        checkOutput("abort.sum", {16'b0, bus.sum}, 32'd0);
        checkOutput("abort.cout", {31'b0, bus.cout}, 32'd0);
        checkOutput("abort.add", {23'b0, bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        donePulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) donePulses++;
        end
        checkOutput("abort.noDone", donePulses, 32'd0);
        applyStimulus(16'hABCD, 16'h1234, 1'b0);
        waitDone(cycles, overlap);
        checkOutput("abort.nextSum", {16'b0, bus.sum}, 32'h0000BE01);
        checkOutput("abort.nextLatency", cycles, 32'd4);
        @(negedge clk);

`ifdef ADD4_SERIAL_SUB_EN
        // Subtraction: op_cin is ignored when op_sub is set.
        bus.op_sub = 1'b1;
        applyStimulus(16'h0005, 16'h0007, 1'b0);
        waitDone(cycles, overlap);
        checkOutput("sub1.sum", {16'b0, bus.sum}, 32'h0000FFFE);
        checkOutput("sub1.cout", {31'b0, bus.cout}, 32'd0);
        @(negedge clk);
        applyStimulus(16'h0007, 16'h0005, 1'b0);
        waitDone(cycles, overlap);
        checkOutput("sub2.sum", {16'b0, bus.sum}, 32'h00000002);
        checkOutput("sub2.cout", {31'b0, bus.cout}, 32'd1);
        bus.op_sub = 1'b0;
        @(negedge clk);
`endif

        // Single-nibble instance: one RUN cycle, done one cycle after accept.
        for (int i = 0; i < 3; i++) begin
            bus1.start  = 1'b1;
            bus1.op_a   = vecs1[i].a[3:0];
            bus1.op_b   = vecs1[i].b[3:0];
            bus1.op_cin = vecs1[i].cin;
            @(negedge clk);
            bus1.start  = 1'b0;
            checkOutput($sformatf("n1v%0d.busy", i), {31'b0, bus1.busy}, 32'd1);
            checkOutput($sformatf("n1v%0d.doneEarly", i), {31'b0, bus1.done}, 32'd0);
            @(negedge clk);
            checkOutput($sformatf("n1v%0d.done", i), {31'b0, bus1.done}, 32'd1);
            checkOutput($sformatf("n1v%0d.sum", i), {28'b0, bus1.sum}, {28'b0, vecs1[i].expSum[3:0]});
            checkOutput($sformatf("n1v%0d.cout", i), {31'b0, bus1.cout}, {31'b0, vecs1[i].expCout});
            @(negedge clk);
            checkOutput($sformatf("n1v%0d.donePulse", i), {31'b0, bus1.done}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
